hls_deadlock_aggregator: RTL and testbench
==========================================

Name: hls_deadlock_aggregator

Overview:
Downstream consumer of the per-instance HLS deadlock monitors. Each monitor drives a registered, level-sensitive "block" flag. This block collects NUM_MON such flags and filters out transient stalls by requiring THRESH consecutive blocked cycles. On a confirmed deadlock it latches a sticky report (first-blocking monitor index, accumulated monitor mask, cycle timestamp) for the simulation harness or a debug register, and holds it until cleared.

Parameters:
NUM_MON, 4, number of monitor block inputs (>=1)
THRESH, 1024, consecutive blocked cycles required to declare deadlock (>=1)
TS_W, 32, width of free-running cycle counter and timestamp
IDX_W, 2, width of monitor index output; must satisfy 2**IDX_W >= NUM_MON

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
monitor_block  input  NUM_MON  block outputs of the deadlock monitors; bit i = monitor i
clear  input  1  synchronous pulse; drops a latched report or the current streak
deadlock_detected  output  1  sticky, high once a deadlock is confirmed, until clear/reset
deadlock_pulse  output  1  one-cycle strobe on the edge deadlock_detected rises
deadlock_first_idx  output  IDX_W  lowest set bit of monitor_block on first sample of the confirmed streak
deadlock_mask  output  NUM_MON  OR of all monitor_block samples over the confirmed streak
deadlock_cycle  output  TS_W  free-running counter value captured at detection
streak_count  output  clog2(THRESH+1)  current consecutive-blocked count, for debug

Behaviour:
- Reset: all outputs 0, state IDLE, free-running counter 0, internal mask accumulator 0.
- Free-running counter: increments every non-reset cycle. Wraps modulo 2**TS_W. Unaffected by clear.
- any_block = OR of monitor_block. All inputs are sampled on the rising edge.
- States: IDLE, WATCH, REPORTED.
- IDLE:
  - If any_block: go to WATCH, streak_count<=1, capture first_idx = lowest set bit, accumulator<=monitor_block.
  - If THRESH==1: go directly to REPORTED with the same captures (see detection).
- WATCH:
  - If any_block: streak_count+1; accumulator |= monitor_block.
  - If !any_block: return to IDLE, streak_count<=0, accumulator<=0.
  - Detection: the edge where the sample makes streak_count equal THRESH moves to REPORTED. On that edge, registered:
    - deadlock_detected<=1, deadlock_pulse<=1.
    - deadlock_mask <= accumulator | monitor_block.
    - deadlock_first_idx <= captured index.
    - deadlock_cycle <= free-running counter value at that edge (pre-increment).
  - Latency: block continuously high from the sample at edge k gives deadlock_detected high after edge k+THRESH-1.
- REPORTED:
  - All report outputs frozen.
  - streak_count saturates at THRESH.
  - monitor_block is ignored, including deassertion; the report is sticky.
  - deadlock_pulse is low from the next cycle.
- clear (highest priority after reset, any state): next state IDLE; streak_count, accumulator and all report outputs <=0. The monitor_block sample on the clear cycle is discarded, so a new streak starts with the first sample after clear.
- Gaps: a single non-blocked sample in WATCH fully restarts the streak. There is no hysteresis.
- Changing blocking set: monitors may hand off (bit 0 falls while bit 2 rises) without breaking the streak, as long as any_block stays high. first_idx keeps the original capture.
- Reset mid-streak or mid-report: identical to power-on reset.
- Widths: streak_count never exceeds THRESH. Comparisons are unsigned.

Test Plan:
1. NUM_MON=4, THRESH=8; monitor_block=4'b0100 held from cycle 10 -> deadlock_detected rises after edge 17; pulse high exactly one cycle; first_idx=2; mask=4'b0100; deadlock_cycle=17.
2. THRESH=8; monitor_block=4'b0001 for 7 cycles, 0 for 1 cycle, then 4'b0001 for 8 cycles -> no detection in the first burst; streak_count returns to 0; detection on the 8th cycle of the second burst.
3. THRESH=8; bits hand off 4'b0010 (3 cycles) -> 4'b1000 (5 cycles), continuous -> detected; first_idx=1; mask=4'b1010.
4. After detection, drop monitor_block to 0 for 20 cycles -> outputs unchanged. Then pulse clear -> all report outputs 0 next cycle. Hold 4'b0001 during clear -> streak_count=1 only one cycle after clear.
5. THRESH=1; monitor_block=4'b0011 for one cycle -> detected after that edge; first_idx=0; mask=4'b0011.
6. Assert reset for one cycle during WATCH (streak_count=5) and again during REPORTED -> all outputs 0 after the reset edge; a subsequent 8-cycle block re-detects normally.

Source files
------------

// File: rtl/hls_deadlock_aggregator.sv
// Collects per-instance HLS deadlock monitor block flags, filters transient stalls,
// and latches a sticky deadlock report (first index, mask, timestamp) until cleared.
module hls_deadlock_aggregator #(
    parameter int unsigned NUM_MON = 4,
    parameter int unsigned THRESH  = 1024,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_MON-1:0]               monitor_block,
    input  logic                             clear,
    output logic                             deadlock_detected,
    output logic                             deadlock_pulse,
    output logic [IDX_W-1:0]                 deadlock_first_idx,
    output logic [NUM_MON-1:0]               deadlock_mask,
    output logic [TS_W-1:0]                  deadlock_cycle,
    output logic [$clog2(THRESH+1)-1:0]      streak_count
);

    localparam int unsigned CNT_W = $clog2(THRESH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        REPORTED = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [TS_W-1:0]      ts_q;
    logic [IDX_W-1:0]     idx_q, idx_nxt;
    logic [NUM_MON-1:0]   acc_q, acc_nxt;
    logic [CNT_W-1:0]     streak_nxt;
    logic                 det_nxt;
    logic                 pulse_nxt;
    logic [IDX_W-1:0]     first_idx_nxt;
    logic [NUM_MON-1:0]   mask_nxt;
    logic [TS_W-1:0]      cycle_nxt;

    logic                 any_block;
    logic [IDX_W-1:0]     low_idx;
    logic [CNT_W-1:0]     streak_inc;

    // Lowest set bit of the current sample; iterating downward lets the lowest win.
    always_comb begin
        low_idx = '0;
        for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
            if (monitor_block[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign any_block  = |monitor_block;
    assign streak_inc = streak_count + CNT_W'(1);

    // Next-state and report capture.
    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak_count;
        idx_nxt       = idx_q;
        acc_nxt       = acc_q;
        det_nxt       = deadlock_detected;
        pulse_nxt     = 1'b0;
        first_idx_nxt = deadlock_first_idx;
        mask_nxt      = deadlock_mask;
        cycle_nxt     = deadlock_cycle;

        if (clear) begin
            state_nxt     = IDLE;
            streak_nxt    = '0;
            idx_nxt       = '0;
            acc_nxt       = '0;
            det_nxt       = 1'b0;
            first_idx_nxt = '0;
            mask_nxt      = '0;
            cycle_nxt     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_block) begin
                        streak_nxt = CNT_W'(1);
                        idx_nxt    = low_idx;
                        acc_nxt    = monitor_block;
                        if (THRESH == 1) begin
                            state_nxt     = REPORTED;
                            det_nxt       = 1'b1;
                            pulse_nxt     = 1'b1;
                            first_idx_nxt = low_idx;
                            mask_nxt      = monitor_block;
                            cycle_nxt     = ts_q;
                        end else begin
                            state_nxt = WATCH;
                        end
                    end
                end
                WATCH: begin
                    if (any_block) begin
                        streak_nxt = streak_inc;
                        acc_nxt    = acc_q | monitor_block;
                        if (streak_inc == CNT_W'(THRESH)) begin
                            state_nxt     = REPORTED;
                            det_nxt       = 1'b1;
                            pulse_nxt     = 1'b1;
                            first_idx_nxt = idx_q;
                            mask_nxt      = acc_q | monitor_block;
                            cycle_nxt     = ts_q;
                        end
                    end else begin
                        state_nxt  = IDLE;
                        streak_nxt = '0;
                        acc_nxt    = '0;
                    end
                end
                REPORTED: begin
                    // Report is sticky; monitors are ignored until clear or reset.
                    streak_nxt = CNT_W'(THRESH);
                end
                default: begin
                    state_nxt  = IDLE;
                    streak_nxt = '0;
                    acc_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            ts_q               <= '0;
            idx_q              <= '0;
            acc_q              <= '0;
            streak_count       <= '0;
            deadlock_detected  <= 1'b0;
            deadlock_pulse     <= 1'b0;
            deadlock_first_idx <= '0;
            deadlock_mask      <= '0;
            deadlock_cycle     <= '0;
        end else begin
            state              <= state_nxt;
            ts_q               <= ts_q + TS_W'(1);
            idx_q              <= idx_nxt;
            acc_q              <= acc_nxt;
            streak_count       <= streak_nxt;
            deadlock_detected  <= det_nxt;
            deadlock_pulse     <= pulse_nxt;
            deadlock_first_idx <= first_idx_nxt;
            deadlock_mask      <= mask_nxt;
            deadlock_cycle     <= cycle_nxt;
        end
    end

endmodule

// File: tb/tb_hls_deadlock_aggregator.sv
// Bench for hls_deadlock_aggregator: table of stimulus segments with expected end values,
// per-cycle scoreboard against a behavioural model, and a THRESH=1 instance for the fast path.
module tb_hls_deadlock_aggregator;

    localparam int unsigned NM  = 4;
    localparam int unsigned TH  = 8;
    localparam int unsigned TSW = 32;
    localparam int unsigned IW  = 2;
    localparam int unsigned CW  = $clog2(TH + 1);

    logic            clk;
    logic            rst;
    logic            clr;
    logic [NM-1:0]   blk;
    logic            det;
    logic            pulse;
    logic [IW-1:0]   fidx;
    logic [NM-1:0]   mask;
    logic [TSW-1:0]  cyc;
    logic [CW-1:0]   streak;

    logic            clr1;
    logic [NM-1:0]   blk1;
    logic            det1;
    logic            pulse1;
    logic [IW-1:0]   fidx1;
    logic [NM-1:0]   mask1;
    logic [TSW-1:0]  cyc1;
    logic [0:0]      streak1;

    hls_deadlock_aggregator #(.NUM_MON(NM), .THRESH(TH), .TS_W(TSW), .IDX_W(IW)) dut (
        .clock(clk), .reset(rst), .monitor_block(blk), .clear(clr),
        .deadlock_detected(det), .deadlock_pulse(pulse), .deadlock_first_idx(fidx),
        .deadlock_mask(mask), .deadlock_cycle(cyc), .streak_count(streak)
    );

    hls_deadlock_aggregator #(.NUM_MON(NM), .THRESH(1), .TS_W(TSW), .IDX_W(IW)) dut1 (
        .clock(clk), .reset(rst), .monitor_block(blk1), .clear(clr1),
        .deadlock_detected(det1), .deadlock_pulse(pulse1), .deadlock_first_idx(fidx1),
        .deadlock_mask(mask1), .deadlock_cycle(cyc1), .streak_count(streak1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        c;
        logic [3:0]  b;
        int          n;
        logic        e_det;
        logic        e_pulse;
        logic [1:0]  e_idx;
        logic [3:0]  e_mask;
        logic [3:0]  e_streak;
        logic [31:0] e_cyc;
    } vec_t;

    typedef struct {
        logic        det;
        logic        pulse;
        logic [1:0]  idx;
        logic [3:0]  mask;
        logic [3:0]  streak;
        logic [31:0] cyc;
    } exp_t;

    vec_t tbl [22];
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state
    int          m_state;
    int          m_streak;
    logic [1:0]  m_cap;
    logic [3:0]  m_acc;
    logic        m_det;
    logic        m_pulse;
    logic [1:0]  m_fidx;
    logic [3:0]  m_mask;
    logic [31:0] m_cyc;
    logic [31:0] m_ts;

    function automatic logic [1:0] low_bit(input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic [3:0] b);
        logic [31:0] ts_old;
        if (r) begin
            m_state = 0; m_streak = 0; m_cap = 0; m_acc = 0;
            m_det = 0; m_pulse = 0; m_fidx = 0; m_mask = 0; m_cyc = 0; m_ts = 0;
            return;
        end
        ts_old  = m_ts;
        m_ts    = m_ts + 1;
        m_pulse = 1'b0;
        if (c) begin
            m_state = 0; m_streak = 0; m_acc = 0;
            m_det = 0; m_fidx = 0; m_mask = 0; m_cyc = 0;
        end else if (m_state == 0) begin
            if (b != 0) begin
                m_state = 1; m_streak = 1; m_cap = low_bit(b); m_acc = b;
            end
        end else if (m_state == 1) begin
            if (b == 0) begin
                m_state = 0; m_streak = 0; m_acc = 0;
            end else begin
                m_streak = m_streak + 1;
                m_acc    = m_acc | b;
                if (m_streak == int'(TH)) begin
                    m_state = 2; m_det = 1; m_pulse = 1;
                    m_mask = m_acc; m_fidx = m_cap; m_cyc = ts_old;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic [3:0] b);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r; clr = c; blk = b;
        model_edge(r, c, b);
        e.det = m_det; e.pulse = m_pulse; e.idx = m_fidx;
        e.mask = m_mask; e.streak = 4'(m_streak); e.cyc = m_cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            got = sb.pop_front();
            chk("sb_cycle", {det, pulse, fidx, mask, streak, cyc},
                {got.det, got.pulse, got.idx, got.mask, got.streak, got.cyc});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; blk = '0; clr1 = 1'b0; blk1 = '0;
        m_state = 0; m_streak = 0; m_cap = 0; m_acc = 0; m_det = 0;
        m_pulse = 0; m_fidx = 0; m_mask = 0; m_cyc = 0; m_ts = 0;

        tbl[0]  = '{1'b1, 1'b0, 4'h0, 2,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 10, 1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[2]  = '{1'b0, 1'b0, 4'h4, 7,  1'b0, 1'b0, 2'd0, 4'h0, 4'd7, 32'd0};
        tbl[3]  = '{1'b0, 1'b0, 4'h4, 1,  1'b1, 1'b1, 2'd2, 4'h4, 4'd8, 32'd17};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 20, 1'b1, 1'b0, 2'd2, 4'h4, 4'd8, 32'd17};
        tbl[5]  = '{1'b0, 1'b1, 4'h1, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'h1, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd1, 32'd0};
        tbl[7]  = '{1'b0, 1'b0, 4'h1, 6,  1'b0, 1'b0, 2'd0, 4'h0, 4'd7, 32'd0};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[9]  = '{1'b0, 1'b0, 4'h1, 7,  1'b0, 1'b0, 2'd0, 4'h0, 4'd7, 32'd0};
        tbl[10] = '{1'b0, 1'b0, 4'h1, 1,  1'b1, 1'b1, 2'd0, 4'h1, 4'd8, 32'd54};
        tbl[11] = '{1'b0, 1'b1, 4'h0, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[12] = '{1'b0, 1'b0, 4'h2, 3,  1'b0, 1'b0, 2'd0, 4'h0, 4'd3, 32'd0};
        tbl[13] = '{1'b0, 1'b0, 4'h8, 4,  1'b0, 1'b0, 2'd0, 4'h0, 4'd7, 32'd0};
        tbl[14] = '{1'b0, 1'b0, 4'h8, 1,  1'b1, 1'b1, 2'd1, 4'ha, 4'd8, 32'd63};
        tbl[15] = '{1'b1, 1'b0, 4'h0, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[16] = '{1'b0, 1'b0, 4'h4, 5,  1'b0, 1'b0, 2'd0, 4'h0, 4'd5, 32'd0};
        tbl[17] = '{1'b1, 1'b0, 4'h4, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[18] = '{1'b0, 1'b0, 4'h1, 8,  1'b1, 1'b1, 2'd0, 4'h1, 4'd8, 32'd7};
        tbl[19] = '{1'b1, 1'b0, 4'h0, 1,  1'b0, 1'b0, 2'd0, 4'h0, 4'd0, 32'd0};
        tbl[20] = '{1'b0, 1'b0, 4'hc, 8,  1'b1, 1'b1, 2'd2, 4'hc, 4'd8, 32'd7};
        tbl[21] = '{1'b0, 1'b0, 4'h0, 1,  1'b1, 1'b0, 2'd2, 4'hc, 4'd8, 32'd7};

        for (int v = 0; v < 22; v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                step(tbl[v].r, tbl[v].c, tbl[v].b);
            end
            chk($sformatf("row%0d_det", v),    64'(det),    64'(tbl[v].e_det));
            chk($sformatf("row%0d_pulse", v),  64'(pulse),  64'(tbl[v].e_pulse));
            chk($sformatf("row%0d_idx", v),    64'(fidx),   64'(tbl[v].e_idx));
            chk($sformatf("row%0d_mask", v),   64'(mask),   64'(tbl[v].e_mask));
            chk($sformatf("row%0d_streak", v), 64'(streak), 64'(tbl[v].e_streak));
            chk($sformatf("row%0d_cycle", v),  64'(cyc),    64'(tbl[v].e_cyc));
        end

        // THRESH=1 instance stayed idle throughout; now a single blocked sample reports.
        chk("t1_idle_det", 64'(det1), 64'd0);
        blk1 = 4'b0011;
        step(1'b0, 1'b0, 4'h0);
        blk1 = 4'b0000;
        chk("t1_det",    64'(det1),    64'd1);
        chk("t1_pulse",  64'(pulse1),  64'd1);
        chk("t1_idx",    64'(fidx1),   64'd0);
        chk("t1_mask",   64'(mask1),   64'h3);
        chk("t1_streak", 64'(streak1), 64'd1);
        chk("t1_cycle",  64'(cyc1),    64'd9);
        step(1'b0, 1'b0, 4'h0);
        chk("t1_sticky_det", 64'(det1),   64'd1);
        chk("t1_pulse_low",  64'(pulse1), 64'd0);
        chk("t1_sticky_mask", 64'(mask1), 64'h3);
        clr1 = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        clr1 = 1'b0;
        chk("t1_clr_det",    64'(det1),    64'd0);
        chk("t1_clr_mask",   64'(mask1),   64'd0);
        chk("t1_clr_streak", 64'(streak1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
